bounce_gen: RTL and testbench

- Switch-bounce emulator: the drive-side counterpart of the team's debouncer.
- Takes a clean target level and drives a pseudo-random bouncing waveform for a programmable window, then settles and holds.
- Used in hardware-in-loop rigs and benches to exercise debounce logic with a repeatable, seeded bounce pattern.

---
 rtl/bounce_gen_pkg.sv | 13 +
 rtl/bounce_lfsr.sv | 29 ++
 rtl/bounce_gen.sv | 161 ++++++++++++++++
 tb/tb_bounce_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the switch-bounce emulator and its LFSR.
package bounce_gen_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        STABLE = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } bounce_state_t;

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit right-shifting Galois LFSR, stepped only when advance is high.
module bounce_lfsr
    import bounce_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_shift;

    // Bit shifted out of the LSB folds the tap mask back in.
    assign w_shift = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_MASK : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= w_shift;
        end
    end

    assign q = r_lfsr;

endmodule

// File: rtl/bounce_gen.sv
// Switch-bounce emulator: turns a clean level change into a seeded, tick-paced
// bouncing waveform, then holds the final level for a guaranteed settle time.
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter int unsigned       TICK_M       = 1000,
    parameter int unsigned       BOUNCE_TICKS = 800,
    parameter int unsigned       SETTLE_TICKS = 200,
    parameter int unsigned       GAP_W        = 4,
    parameter logic [LFSR_W-1:0] SEED         = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level_in,
    input  logic       enable,
    output logic       sw_out,
    output logic       busy,
    output logic [7:0] bounce_cnt
);

    localparam int unsigned PRESC_W = $clog2(TICK_M + 1);
    localparam int unsigned WIN_W   = $clog2(BOUNCE_TICKS + 1);
    localparam int unsigned HOLD_W  = $clog2(SETTLE_TICKS + 1);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    // Free-running prescaler; never realigned to input events.
    assign w_tick = (r_presc == PRESC_W'(TICK_M - 1));

    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    logic [LFSR_W-1:0] w_lfsr;
    logic [GAP_W-1:0]  w_gap_raw;
    logic [GAP_W-1:0]  w_gap_val;
    logic              w_unused_lfsr;

    bounce_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (w_tick),
        .q       (w_lfsr)
    );

    // A zero gap would stall the toggle schedule, so it is promoted to one tick.
    assign w_gap_raw     = w_lfsr[GAP_W-1:0];
    assign w_gap_val     = (w_gap_raw == '0) ? GAP_W'(1) : w_gap_raw;
    assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:GAP_W];

    bounce_state_t      r_state;
    logic               r_sw;
    logic               r_busy;
    logic [7:0]         r_cnt;
    logic               r_settled;
    logic               r_target;
    logic [WIN_W-1:0]   r_window;
    logic [GAP_W-1:0]   r_gap;
    logic [HOLD_W-1:0]  r_hold;

    logic [WIN_W-1:0]   w_window_dec;
    logic [GAP_W-1:0]   w_gap_dec;
    logic [HOLD_W-1:0]  w_hold_dec;
    logic [7:0]         w_cnt_inc;

    assign w_window_dec = r_window - WIN_W'(1);
    assign w_gap_dec    = r_gap - GAP_W'(1);
    assign w_hold_dec   = r_hold - HOLD_W'(1);
    assign w_cnt_inc    = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= STABLE;
            r_sw      <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= 8'd0;
            r_settled <= 1'b0;
            r_target  <= 1'b0;
            r_window  <= '0;
            r_gap     <= '0;
            r_hold    <= '0;
        end else begin
            case (r_state)
                STABLE: begin
                    r_busy <= 1'b0;
                    if (!enable) begin
                        r_settled <= level_in;
                        r_sw      <= level_in;
                    end else if (level_in != r_settled) begin
                        r_target <= level_in;
                        r_sw     <= ~r_sw;
                        r_cnt    <= 8'd1;
                        r_window <= WIN_W'(BOUNCE_TICKS);
                        r_gap    <= w_gap_val;
                        r_busy   <= 1'b1;
                        r_state  <= BOUNCE;
                    end
                end
                BOUNCE: begin
                    if (!enable) begin
                        r_state   <= STABLE;
                        r_settled <= level_in;
                        r_sw      <= level_in;
                        r_busy    <= 1'b0;
                    end else if (w_tick && (w_window_dec == '0)) begin
                        // Window end forces the target level, overriding any gap expiry.
                        r_sw <= r_target;
                        if (r_sw != r_target) begin
                            r_cnt <= w_cnt_inc;
                        end
                        r_hold  <= HOLD_W'(SETTLE_TICKS);
                        r_state <= SETTLE;
                    end else begin
                        r_target <= level_in;
                        if (w_tick) begin
                            r_window <= w_window_dec;
                            if (w_gap_dec == '0) begin
                                r_sw  <= ~r_sw;
                                r_gap <= w_gap_val;
                                r_cnt <= w_cnt_inc;
                            end else begin
                                r_gap <= w_gap_dec;
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (!enable) begin
                        r_state   <= STABLE;
                        r_settled <= level_in;
                        r_sw      <= level_in;
                        r_busy    <= 1'b0;
                    end else if (w_tick) begin
                        r_hold <= w_hold_dec;
                        if (w_hold_dec == '0) begin
                            r_settled <= r_target;
                            r_busy    <= 1'b0;
                            r_state   <= STABLE;
                        end
                    end
                end
                default: begin
                    r_state <= STABLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sw_out     = r_sw;
    assign busy       = r_busy;
    assign bounce_cnt = r_cnt;

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen against an event-level reference model.
module tb_bounce_gen;

    localparam int unsigned TM = 4;
    localparam int unsigned BT = 10;
    localparam int unsigned ST = 3;
    localparam int unsigned GW = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       level_in = 1'b0;
    logic       enable = 1'b0;
    logic       sw_out;
    logic       busy;
    logic [7:0] bounce_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    bounce_gen #(
        .TICK_M       (TM),
        .BOUNCE_TICKS (BT),
        .SETTLE_TICKS (ST),
        .GAP_W        (GW),
        .SEED         (16'hACE1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .level_in   (level_in),
        .enable     (enable),
        .sw_out     (sw_out),
        .busy       (busy),
        .bounce_cnt (bounce_cnt)
    );

    // Reference model: mode 0 idle, 1 bouncing, 2 settling; times kept as elapsed tick counts.
    int          m_mode;
    bit          m_out, m_busy, m_settled, m_target, m_last_tick;
    int          m_cnt, m_presc, m_el, m_next, m_sel;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    task automatic model_edge();
        bit tick;
        int gv;
        tick = (m_presc == int'(TM) - 1);
        m_last_tick = tick;
        gv = int'(m_lfsr[GW-1:0]);
        if (gv == 0) gv = 1;
        if (reset) begin
            m_mode = 0; m_out = 0; m_busy = 0; m_settled = 0; m_target = 0;
            m_cnt = 0; m_presc = 0; m_lfsr = 16'hACE1; m_el = 0; m_next = 0; m_sel = 0;
            m_last_tick = 0;
            return;
        end
        if (m_mode == 0) begin
            if (!enable) begin
                m_settled = level_in;
                m_out = level_in;
            end else if (level_in != m_settled) begin
                m_target = level_in;
                m_out = !m_out;
                m_cnt = 1;
                m_el = 0;
                m_next = gv;
                m_mode = 1;
                m_busy = 1;
            end
        end else if (!enable) begin
            m_mode = 0; m_settled = level_in; m_out = level_in; m_busy = 0;
        end else if (m_mode == 1) begin
            if (tick) begin
                m_el++;
                if (m_el == int'(BT)) begin
                    if (m_out != m_target && m_cnt < 255) m_cnt++;
                    m_out = m_target;
                    m_sel = 0;
                    m_mode = 2;
                end else begin
                    m_target = level_in;
                    if (m_el == m_next) begin
                        m_out = !m_out;
                        if (m_cnt < 255) m_cnt++;
                        m_next = m_el + gv;
                    end
                end
            end else begin
                m_target = level_in;
            end
        end else begin
            if (tick) begin
                m_sel++;
                if (m_sel == int'(ST)) begin
                    m_settled = m_target;
                    m_mode = 0;
                    m_busy = 0;
                end
            end
        end
        if (tick) begin
            m_lfsr = lfsr_next(m_lfsr);
            m_presc = 0;
        end else begin
            m_presc++;
        end
    endtask

    task automatic step(input bit r, input bit l, input bit e);
        reset = r;
        level_in = l;
        enable = e;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 1);
            checks++;
            if ({sw_out, busy, bounce_cnt} !== 10'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got sw=%b busy=%b cnt=%0d want 0/0/0", cyc, sw_out, busy, bounce_cnt);
            end
        end
        step(0, 1, 1);
        checks++;
        if (sw_out !== 1'b1 || busy !== 1'b1 || bounce_cnt !== 8'd1) begin
            errors++;
            $display("FAIL reset_release_event got sw=%b busy=%b cnt=%0d want 1/1/1", sw_out, busy, bounce_cnt);
        end
        for (int i = 0; i < 200 && m_busy; i++) begin
            step(0, 1, 1);
            checks++;
            if ({sw_out, busy, bounce_cnt} !== {m_out, m_busy, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL reset_event cyc=%0d got sw=%b busy=%b cnt=%0d want %b/%b/%0d", cyc, sw_out, busy, bounce_cnt, m_out, m_busy, m_cnt);
            end
        end
        checks++;
        if (m_busy) begin
            errors++;
            $display("FAIL reset_event_timeout got busy=%b want 0", busy);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] cnt_exp;
        cnt_exp = 8'(m_cnt);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        checks++;
        if (sw_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bypass_low got sw=%b busy=%b want 0/0", sw_out, busy);
        end
        step(0, 1, 0);
        checks++;
        if (sw_out !== 1'b1 || busy !== 1'b0 || bounce_cnt !== cnt_exp) begin
            errors++;
            $display("FAIL bypass_rise got sw=%b busy=%b cnt=%0d want 1/0/%0d", sw_out, busy, bounce_cnt, cnt_exp);
        end
        step(0, 0, 0);
        checks++;
        if (sw_out !== 1'b0 || busy !== 1'b0 || bounce_cnt !== cnt_exp) begin
            errors++;
            $display("FAIL bypass_fall got sw=%b busy=%b cnt=%0d want 0/0/%0d", sw_out, busy, bounce_cnt, cnt_exp);
        end
    endtask

    task automatic test_full_event();
        int nticks;
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 1, 1);
        checks++;
        if (sw_out !== 1'b1 || busy !== 1'b1 || bounce_cnt !== 8'd1) begin
            errors++;
            $display("FAIL full_start got sw=%b busy=%b cnt=%0d want 1/1/1", sw_out, busy, bounce_cnt);
        end
        nticks = 0;
        for (int i = 0; i < 200 && m_busy; i++) begin
            step(0, 1, 1);
            if (m_last_tick) nticks++;
            checks++;
            if ({sw_out, busy, bounce_cnt} !== {m_out, m_busy, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL full_model cyc=%0d got sw=%b busy=%b cnt=%0d want %b/%b/%0d", cyc, sw_out, busy, bounce_cnt, m_out, m_busy, m_cnt);
            end
            if (m_mode == 2) begin
                checks++;
                if (sw_out !== 1'b1) begin
                    errors++;
                    $display("FAIL full_settle_hold cyc=%0d got sw=%b want 1", cyc, sw_out);
                end
            end
        end
        checks++;
        if (nticks != int'(BT + ST) || busy !== 1'b0 || sw_out !== 1'b1) begin
            errors++;
            $display("FAIL full_end got ticks=%0d busy=%b sw=%b want %0d/0/1", nticks, busy, sw_out, BT + ST);
        end
    endtask

    task automatic test_retarget();
        int nticks;
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 1, 1);
        nticks = 0;
        for (int i = 0; i < 200 && m_busy; i++) begin
            step(0, (nticks < 3) ? 1'b1 : 1'b0, 1);
            if (m_last_tick) nticks++;
            checks++;
            if ({sw_out, busy, bounce_cnt} !== {m_out, m_busy, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL retarget_model cyc=%0d got sw=%b busy=%b cnt=%0d want %b/%b/%0d", cyc, sw_out, busy, bounce_cnt, m_out, m_busy, m_cnt);
            end
        end
        checks++;
        if (nticks != int'(BT + ST) || sw_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL retarget_end got ticks=%0d sw=%b busy=%b want %0d/0/0", nticks, sw_out, busy, BT + ST);
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1);
            checks++;
            if (busy !== 1'b0 || sw_out !== 1'b0) begin
                errors++;
                $display("FAIL retarget_no_event cyc=%0d got busy=%b sw=%b want 0/0", cyc, busy, sw_out);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] cnt_exp;
        step(0, 1, 1);
        for (int i = 0; i < 100 && m_el < 4; i++) step(0, 1, 1);
        checks++;
        if (busy !== 1'b1 || m_mode != 1) begin
            errors++;
            $display("FAIL abort_precond got busy=%b want 1", busy);
        end
        cnt_exp = 8'(m_cnt);
        step(0, 1, 0);
        checks++;
        if (sw_out !== 1'b1 || busy !== 1'b0 || bounce_cnt !== cnt_exp) begin
            errors++;
            $display("FAIL abort got sw=%b busy=%b cnt=%0d want 1/0/%0d", sw_out, busy, bounce_cnt, cnt_exp);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0);
            checks++;
            if (sw_out !== 1'b1 || busy !== 1'b0 || bounce_cnt !== cnt_exp) begin
                errors++;
                $display("FAIL abort_frozen cyc=%0d got sw=%b busy=%b cnt=%0d want 1/0/%0d", cyc, sw_out, busy, bounce_cnt, cnt_exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit         tr_sw[$];
        logic [7:0] tr_cnt[$];
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 1, 1);
        for (int i = 0; i < 200 && m_el < 5; i++) begin
            tr_sw.push_back(m_out);
            tr_cnt.push_back(8'(m_cnt));
            step(0, 1, 1);
            checks++;
            if ({sw_out, busy, bounce_cnt} !== {m_out, m_busy, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL rstmid_run1 cyc=%0d got sw=%b busy=%b cnt=%0d want %b/%b/%0d", cyc, sw_out, busy, bounce_cnt, m_out, m_busy, m_cnt);
            end
        end
        step(1, 1, 1);
        checks++;
        if ({sw_out, busy, bounce_cnt} !== 10'd0 || dut.u_lfsr.q !== 16'hACE1) begin
            errors++;
            $display("FAIL rstmid_values got sw=%b busy=%b cnt=%0d lfsr=%h want 0/0/0/ace1", sw_out, busy, bounce_cnt, dut.u_lfsr.q);
        end
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 1, 1);
        foreach (tr_sw[i]) begin
            checks++;
            if (sw_out !== tr_sw[i] || bounce_cnt !== tr_cnt[i]) begin
                errors++;
                $display("FAIL rstmid_replay idx=%0d got sw=%b cnt=%0d want %b/%0d", i, sw_out, bounce_cnt, tr_sw[i], tr_cnt[i]);
            end
            step(0, 1, 1);
        end
        for (int i = 0; i < 200 && m_busy; i++) begin
            step(0, 1, 1);
            checks++;
            if ({sw_out, busy, bounce_cnt} !== {m_out, m_busy, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL rstmid_tail cyc=%0d got sw=%b busy=%b cnt=%0d want %b/%b/%0d", cyc, sw_out, busy, bounce_cnt, m_out, m_busy, m_cnt);
            end
        end
    endtask

    task automatic test_random();
        bit lvl, en, rst;
        lvl = level_in;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) lvl = !lvl;
            en  = ($urandom_range(0, 149) != 0);
            rst = ($urandom_range(0, 999) == 0);
            step(rst, lvl, en);
            checks++;
            if ({sw_out, busy, bounce_cnt} !== {m_out, m_busy, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL random cyc=%0d got sw=%b busy=%b cnt=%0d want %b/%b/%0d", cyc, sw_out, busy, bounce_cnt, m_out, m_busy, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_full_event();
        test_retarget();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
